// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic DEPTH-stage register chain with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
// Stage 0 is the input side. Stage DEPTH-1 drives the output directly.
module pipe_stage_chain #(
  parameter int              WIDTH = 32,
  parameter int              DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}},
  localparam int             CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $fatal(1, "pipe_stage_chain: DEPTH must be within 1..16");
    end
  endgenerate

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] load_en;
  logic [DEPTH:0]   ready_chain;
  logic [WIDTH-1:0] data_reg [DEPTH];
  logic [WIDTH-1:0] up_data  [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             accept;

  // A stage can take new data if it is empty or everything downstream of it moves.
  always_comb begin
    ready_chain        = '0;
    ready_chain[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready_chain[k] = ~valid_reg[k] | ready_chain[k + 1];
    end
  end

  assign in_ready = ready_chain[0] & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  // Next valid per stage: flush clears everything, a ready stage takes its upstream valid.
  always_comb begin
    up_valid    = '0;
    up_valid[0] = accept;
    for (int k = 1; k < DEPTH; k++) begin
      up_valid[k] = valid_reg[k - 1];
    end
    valid_next = '0;
    load_en    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_next[k] = flush ? 1'b0 : (ready_chain[k] ? up_valid[k] : valid_reg[k]);
      load_en[k]    = ~flush & ready_chain[k] & up_valid[k];
    end
  end

  // Occupancy of the next state, registered alongside the valid bits.
  always_comb begin
    count_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_next = count_next + CW'(valid_next[k]);
    end
  end

  // Valid bits and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign up_data[gi] = in_data;
      end else begin : g_rest
        assign up_data[gi] = data_reg[gi - 1];
      end

      // Data only moves with a valid item; bubbles and flush leave it untouched.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg[gi] <= INIT;
        end else if (load_en[gi]) begin
          data_reg[gi] <= up_data[gi];
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg[DEPTH - 1];
  assign out_data  = data_reg[DEPTH - 1];
  assign count     = count_reg;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (WIDTH=8, DEPTH=3, INIT=8'hA5).
// Items are tracked as a queue with slot positions that compact toward the output.
module tb_pipe_stage_chain;
  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam logic [7:0] INIT = 8'hA5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } item_t;

  item_t      q[$];
  logic [7:0] last_out;
  logic       pend_accept, pend_pop, pend_flush;
  logic [7:0] pend_data;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_out = INIT;
  endtask

  // Drive inputs for one cycle and compare outputs against the model.
  task automatic drive_check(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic e_ir, e_ov;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    e_ir = !fl && ((q.size() < DEPTH) || ordy);
    e_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
    chk("in_ready",  32'(in_ready),  32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("out_data",  32'(out_data),  32'(last_out));
    chk("count",     32'(count),     32'(q.size()));
    $display("cyc t=%0t iv=%0b id=%02h ordy=%0b fl=%0b | ir=%0b ov=%0b od=%02h cnt=%0d",
             $time, iv, id, ordy, fl, in_ready, out_valid, out_data, count);
    pend_accept = iv && e_ir;
    pend_pop    = e_ov && ordy;
    pend_flush  = fl;
    pend_data   = id;
  endtask

  // Advance the model across one clock edge.
  task automatic model_edge();
    int lim;
    int np;
    if (pend_pop) void'(q.pop_front());
    if (pend_flush) begin
      q.delete();
    end else begin
      lim = DEPTH;
      for (int i = 0; i < q.size(); i++) begin
        np = q[i].pos + 1;
        if (np > lim - 1) np = lim - 1;
        q[i].pos = np;
        lim = np;
      end
      if (pend_accept) q.push_back('{data: pend_data, pos: 0});
      if (q.size() > 0 && q[0].pos == DEPTH - 1) last_out = q[0].data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    // Streaming, back-pressure fill and simultaneous push/pop.
    vt[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0};
    vt[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd1};
    vt[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd2};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd3};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd2};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd1};
    vt[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd0};
    vt[7]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd1};
    vt[8]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'd2};
    vt[9]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    vt[10] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3};
    vt[11] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3};
    vt[12] = '{1'b1, 8'h15, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 2'd3};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 2'd3};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h14, 2'd2};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 2'd1};
    vt[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15, 2'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'hA5);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 17; i++) begin
      drive_check(vt[i].iv, vt[i].id, vt[i].ordy, vt[i].fl);
      chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(vt[i].e_od));
      chk($sformatf("vec%0d_count", i),     32'(count),     32'(vt[i].e_cnt));
      tick();
    end

    // Bubble collapse: one item parked in the last stage, then a second behind it.
    drive_check(1'b1, 8'hA0, 1'b0, 1'b0); tick();
    drive_check(1'b0, 8'h00, 1'b0, 1'b0); tick();
    drive_check(1'b0, 8'h00, 1'b0, 1'b0); tick();
    drive_check(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bub_parked_count", 32'(count), 32'd1);
    chk("bub_parked_ov",    32'(out_valid), 32'd1);
    chk("bub_parked_od",    32'(out_data), 32'hA0);
    tick();
    drive_check(1'b1, 8'hB0, 1'b0, 1'b0);
    chk("bub_push_ready", 32'(in_ready), 32'd1);
    tick();
    drive_check(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bub_count", 32'(count), 32'd2);
    chk("bub_od",    32'(out_data), 32'hA0);
    tick();

    // Flush colliding with push and pop.
    drive_check(1'b1, 8'hC0, 1'b1, 1'b1);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_ov",       32'(out_valid), 32'd1);
    chk("fl_count",    32'(count), 32'd2);
    tick();
    drive_check(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fl_after_count", 32'(count), 32'd0);
    chk("fl_after_ov",    32'(out_valid), 32'd0);
    tick();

    // Async reset while full, then a clean restart.
    for (int i = 0; i < 3; i++) begin
      drive_check(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      tick();
    end
    drive_check(1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov",    32'(out_valid), 32'd0);
    chk("arst_od",    32'(out_data),  32'hA5);
    chk("arst_count", 32'(count),     32'd0);
    chk("arst_ir",    32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_check(1'b1, 8'h7E, 1'b1, 1'b0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      drive_check(1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 3) begin
        chk("restart_ov_early", 32'(out_valid), 32'd0);
      end else begin
        chk("restart_ov", 32'(out_valid), 32'd1);
        chk("restart_od", 32'(out_data), 32'h7E);
      end
      tick();
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_check($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline register chain. It generalises the single-stage register primitives to DEPTH stages of WIDTH bits, using a valid/ready handshake, bubble collapsing, synchronous flush and an occupancy count. It sits between core pipeline sections and between core and memory/IO paths wherever a multi-cycle, back-pressurable delay line is needed.

Parameters:
WIDTH, 32, data bits per stage
DEPTH, 2, number of register stages (legal range 1..16)
INIT, {WIDTH{1'b0}}, data value loaded into every stage on reset
CW, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous discard of all stage contents
in_valid  in  1  upstream has data
in_ready  out  1  chain accepts in_data this cycle
in_data  in  WIDTH  upstream data
out_valid  out  1  last stage holds valid data
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  WIDTH  data of last stage
count  out  CW  number of valid stages (0..DEPTH)

Behaviour:
- State: per-stage valid bit v[k] and data d[k]. Stage 0 is the input side; stage DEPTH-1 is the output side.
- Reset (asynchronous, rst=1 at any time): all v[k]=0 and all d[k]=INIT immediately.
  - Outputs during reset: out_valid=0, out_data=INIT, count=0, in_ready=0.
  - The first accept is possible on the first posedge after rst deasserts.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[k] = !v[k] | r[k+1].
  - in_ready = r[0] & !flush & !rst.
- Stage update on posedge, when flush=0:
  - if r[k]: v[k] <= (k==0 ? in_valid & in_ready : v[k-1]).
  - d[k] loads the upstream data only when the incoming valid is 1. On a bubble, d[k] holds its value.
  - if !r[k]: stage holds v[k] and d[k].
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_data is sampled only on an input transfer.
- Bubble collapsing: an empty stage accepts from upstream even when downstream is stalled. The chain therefore fills to DEPTH entries under sustained out_ready=0.
- Latency and throughput:
  - Unstalled, an item accepted at edge t is presented at out_valid after edge t+DEPTH-1, i.e. visible in cycle t+DEPTH.
  - Sustained throughput is 1 item per cycle with out_ready held high.
- Full: all v[k]=1 and out_ready=0 gives in_ready=0.
  - Full with out_ready=1: in_ready=1. Simultaneous push and pop is allowed; count is unchanged.
- Empty: out_valid=0, count=0, in_ready=1 (unless flush or rst).
- Flush (synchronous): at the edge where flush=1, all v[k] <= 0 and d[k] hold.
  - in_ready=0 during flush, so a simultaneous in_valid is dropped.
  - If out_valid&out_ready&flush in the same cycle, that output transfer still counts as consumed.
  - Flush has priority over all stage updates.
- count: registered popcount of v[] (or equivalent up/down counter). It must equal popcount(v) every cycle.
- Ordering: items exit in acceptance order. There is no duplication or loss except through flush or rst.
- out_data is d[DEPTH-1] directly. There is no combinational path from in_data to out_data for any DEPTH.
- DEPTH outside 1..16 is a fatal elaboration error.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, INIT=8'hA5, assert rst mid-cycle → out_valid=0, out_data=8'hA5, count=0 immediately, without waiting for a clock edge.
- Streaming: DEPTH=3, out_ready=1, push 0x01,0x02,0x03 on consecutive edges → out_valid first seen 3 cycles after the first accept, and data 0x01,0x02,0x03 appears on consecutive cycles.
- Back-pressure fill: out_ready=0, in_valid=1 for 5 cycles → exactly 3 accepts, then in_ready=0 with count=3. Raising out_ready → simultaneous push/pop with count staying 3, and output order preserved.
- Bubble collapse: fill stage 2 only, out_ready=0, then push one item → it advances to stage 1 on the next edge, count=2, and out_data is unchanged.
- Flush collision: count=2, flush=1 with in_valid=1 and out_ready=1 → the out transfer completes, then next cycle count=0, out_valid=0, and the input is not accepted.
- Async reset mid-stream: assert rst between edges while full → all valids clear instantly. After release, first push 0x7E → out 0x7E after DEPTH cycles, with no stale data.
